// File: rtl/dtc_pipe_pkg.sv
// Shared constants, typedefs and helpers for the programmable pipelined
// decision-tree classifier.
//   N_FEAT_DEF / DEPTH_DEF / CLASS_W_DEF : default geometry
//   node_addr_t / leaf_addr_t            : table address types
//   feat_idx_t / class_t                 : table payload types
//   heap_index()                         : node heap index from level + path
package dtc_pipe_pkg;

  localparam int unsigned N_FEAT_DEF  = 12;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned CLASS_W_DEF = 3;
  localparam int unsigned FIDX_W_DEF  = $clog2(N_FEAT_DEF);

  typedef logic [DEPTH_DEF-1:0]   node_addr_t;
  typedef logic [DEPTH_DEF-1:0]   leaf_addr_t;
  typedef logic [FIDX_W_DEF-1:0]  feat_idx_t;
  typedef logic [CLASS_W_DEF-1:0] class_t;

  // Heap index of the node reached at 'level' after the decisions in 'path'
  // (decisions stored LSB-aligned, oldest decision in the highest used bit).
  function automatic int unsigned heap_index(input int unsigned level,
                                             input int unsigned path);
    return (32'd1 << level) | path;
  endfunction

endpackage

// File: rtl/dtc_level_stage.sv
// One tree level: forms the node heap index for this level, takes the split
// feature read from the node table, and appends the decision bit to the path.
//   inp         : feature vector held in this stage
//   path        : decisions so far (LEVEL bits, LSB-aligned)
//   feat        : split feature index read from node table at node_idx_c
//   node_idx_c  : node table read address for this level
//   next_path_c : path including this level's decision
module dtc_level_stage
  import dtc_pipe_pkg::*;
#(
  parameter  int unsigned N_FEAT = N_FEAT_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned LEVEL  = 0,
  localparam int unsigned FIDX_W = $clog2(N_FEAT)
) (
  input  logic [N_FEAT-1:0] inp,
  input  logic [DEPTH-1:0]  path,
  input  logic [FIDX_W-1:0] feat,
  output logic [DEPTH-1:0]  node_idx_c,
  output logic [DEPTH-1:0]  next_path_c
);

  logic dec;

  assign node_idx_c = DEPTH'(heap_index(LEVEL, 32'(path)));

  // Decision bit; a feature index past the vector width reads as 0.
  always_comb begin
    dec = 1'b0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (feat == FIDX_W'(i)) dec = inp[i];
    end
  end

  assign next_path_c = (path << 1) | DEPTH'(dec);

endmodule

// File: rtl/dtc_pipe_prog.sv
// Programmable pipelined binary decision-tree classifier. One tree level per
// stage, one classification per cycle, run-time writable node/leaf tables.
//   clk, rst             : clock, synchronous active-high reset
//   inp/in_valid/in_ready: feature vector input handshake
//   outp/out_valid/out_ready : class result output handshake
//   cfg_we/cfg_sel/cfg_addr/cfg_data : table write port (sel 0 node, 1 leaf)
//   idle                 : no valid data anywhere in the pipe
//   cfg_err              : one-cycle pulse when a write is rejected (not idle)
module dtc_pipe_prog
  import dtc_pipe_pkg::*;
#(
  parameter  int unsigned N_FEAT  = N_FEAT_DEF,
  parameter  int unsigned DEPTH   = DEPTH_DEF,
  parameter  int unsigned CLASS_W = CLASS_W_DEF,
  localparam int unsigned FIDX_W  = $clog2(N_FEAT),
  localparam int unsigned CFG_W   = (FIDX_W > CLASS_W) ? FIDX_W : CLASS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FEAT-1:0]  inp,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CLASS_W-1:0] outp,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [DEPTH-1:0]   cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic               idle,
  output logic               cfg_err
);

  localparam int unsigned N_ENT = 1 << DEPTH;

  logic [FIDX_W-1:0]  node_tbl [N_ENT];
  logic [CLASS_W-1:0] leaf_tbl [N_ENT];

  logic [DEPTH-1:0]   s_valid;
  logic [N_FEAT-1:0]  s_inp  [DEPTH];
  logic [DEPTH-1:0]   s_path [DEPTH];

  logic [DEPTH-1:0]   node_idx_c  [DEPTH];
  logic [DEPTH-1:0]   next_path_c [DEPTH];
  logic [FIDX_W-1:0]  feat_c      [DEPTH];

  logic stall_c;
  logic accept_c;
  logic cfg_ok_c;

  // Global enable: a stalled output freezes the whole pipe.
  assign stall_c  = out_valid && !out_ready;
  assign in_ready = !stall_c && !cfg_we;
  assign accept_c = in_valid && in_ready;
  assign idle     = !((|s_valid) || out_valid);
  assign cfg_ok_c = cfg_we && idle;

  // One evaluator per level, each with its own node table read port.
  for (genvar k = 0; k < DEPTH; k++) begin : g_level
    dtc_level_stage #(
      .N_FEAT (N_FEAT),
      .DEPTH  (DEPTH),
      .LEVEL  (k)
    ) u_stage (
      .inp         (s_inp[k]),
      .path        (s_path[k]),
      .feat        (feat_c[k]),
      .node_idx_c  (node_idx_c[k]),
      .next_path_c (next_path_c[k])
    );
    assign feat_c[k] = node_tbl[node_idx_c[k]];
  end

  // Stage and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid   <= '0;
      out_valid <= 1'b0;
      outp      <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        s_inp[k]  <= '0;
        s_path[k] <= '0;
      end
    end else if (!stall_c) begin
      s_valid[0] <= accept_c;
      s_inp[0]   <= inp;
      s_path[0]  <= '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        s_valid[k] <= s_valid[k-1];
        s_inp[k]   <= s_inp[k-1];
        s_path[k]  <= next_path_c[k-1];
      end
      out_valid <= s_valid[DEPTH-1];
      if (s_valid[DEPTH-1]) outp <= leaf_tbl[next_path_c[DEPTH-1]];
    end
  end

  // Table writes only land while the pipe is empty; node 0 does not exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int unsigned i = 0; i < N_ENT; i++) begin
        node_tbl[i] <= '0;
        leaf_tbl[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !idle;
      if (cfg_ok_c) begin
        if (cfg_sel) begin
          leaf_tbl[cfg_addr] <= cfg_data[CLASS_W-1:0];
        end else if (cfg_addr != '0) begin
          node_tbl[cfg_addr] <= cfg_data[FIDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dtc_pipe_prog.sv
// Directed bench for dtc_pipe_prog with a reference tree walk feeding a
// scoreboard queue; results are popped and compared on output transfers.
module tb_dtc_pipe_prog;

  localparam int unsigned N_FEAT  = 12;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLASS_W = 3;
  localparam int unsigned NE      = 16;

  logic               clk;
  logic               rst;
  logic [N_FEAT-1:0]  inp;
  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] outp;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_we;
  logic               cfg_sel;
  logic [DEPTH-1:0]   cfg_addr;
  logic [3:0]         cfg_data;
  logic               idle;
  logic               cfg_err;

  dtc_pipe_prog dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outp      (outp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .idle      (idle),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int node_m [NE];
  int leaf_m [NE];
  logic [CLASS_W-1:0] sb [$];
  int cyc = 0;
  bit track_gaps = 0;
  int prev_out = -1;
  int outs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference tree walk over the bench's own copy of the tables.
  function automatic logic [CLASS_W-1:0] model(input logic [N_FEAT-1:0] x);
    int path = 0;
    int node;
    int f;
    bit d;
    for (int k = 0; k < DEPTH; k++) begin
      node = (1 << k) | path;
      f    = node_m[node];
      d    = (f < N_FEAT) ? x[f] : 1'b0;
      path = (path << 1) | int'(d);
    end
    return CLASS_W'(leaf_m[path]);
  endfunction

  // One clock: sample handshakes before the edge, score after it.
  task automatic tick();
    bit in_x;
    bit out_x;
    logic [CLASS_W-1:0] o;
    logic [N_FEAT-1:0] v;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    o     = outp;
    v     = inp;
    @(posedge clk);
    cyc++;
    #1;
    if (in_x) sb.push_back(model(v));
    if (out_x) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("result", 32'(o), 32'(sb.pop_front()));
      outs++;
      if (track_gaps && prev_out >= 0) chk("b2b_gap", 32'(cyc - prev_out), 32'd1);
      prev_out = cyc;
    end
  endtask

  task automatic cfg_write(input bit sel, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = DEPTH'(addr);
    cfg_data = 4'(data);
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_idle", 32'(cfg_err), 32'd0);
    if (sel) leaf_m[addr] = data & 7;
    else if (addr != 0) node_m[addr] = data & 15;
  endtask

  task automatic send(input logic [N_FEAT-1:0] v);
    in_valid = 1'b1;
    inp      = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 64) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("idle_after_drain", 32'(idle), 32'd1);
  endtask

  task automatic wait_out();
    int n = 0;
    while (out_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_FEAT-1:0] b2b [8];
    int n;
    b2b = '{12'h000, 12'h008, 12'h040, 12'h048, 12'h200, 12'h208, 12'h240, 12'h248};
    for (int i = 0; i < NE; i++) begin
      node_m[i] = 0;
      leaf_m[i] = 0;
    end
    rst = 1'b1; inp = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outp", 32'(outp), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Program the reference tree.
    for (int i = 1; i < NE; i++) cfg_write(1'b0, i, (i == 1) ? 6 : (i < 4) ? 3 : 9);
    for (int i = 0; i < NE; i++) cfg_write(1'b1, i, i >> 1);

    // Latency: out_valid four edges after the accepting edge.
    send(12'h040);
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("outp_040", 32'(outp), 32'd4);
    drain();

    // Back-to-back stream: consecutive outputs in order.
    track_gaps = 1; prev_out = -1; outs = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      inp      = b2b[i];
      tick();
    end
    in_valid = 1'b0;
    drain();
    track_gaps = 0;
    chk("b2b_count", 32'(outs), 32'd8);

    // Stall with three items in flight.
    out_ready = 1'b0;
    send(12'h048);
    send(12'h208);
    send(12'hFFF);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_outp", 32'(outp), 32'(sb[0]));
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_sb", 32'(sb.size()), 32'd3);
    end
    out_ready = 1'b1;
    outs = 0;
    drain();
    chk("stall_delivered", 32'(outs), 32'd3);

    // Write while busy is rejected and blocks input that cycle.
    send(12'h040);
    in_valid = 1'b1; inp = 12'h248;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd1; cfg_data = 4'd3;
    #1;
    chk("cfgwe_in_ready", 32'(in_ready), 32'd0);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    tick();
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    drain();
    send(12'h040);
    wait_out();
    chk("tbl_unchanged", 32'(outp), 32'd4);
    drain();

    // Node address 0 is dropped silently; out-of-range feature reads as 0.
    cfg_write(1'b0, 0, 5);
    cfg_write(1'b0, 1, 13);
    send(12'hFFF);
    send(12'h040);
    drain();

    // Upper cfg_data bits are ignored for the 3-bit leaf class.
    cfg_write(1'b1, 7, 4'hD);
    send(12'hFFF);
    wait_out();
    chk("leaf_mask", 32'(outp), 32'd5);
    drain();

    // Reset with items in flight.
    send(12'h040);
    send(12'h048);
    send(12'h208);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    for (int i = 0; i < NE; i++) begin
      node_m[i] = 0;
      leaf_m[i] = 0;
    end
    send(12'h040);
    wait_out();
    chk("post_rst_outp", 32'(outp), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
